// File: rtl/sr_ff_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_ff_driver
// Purpose  : Command-side controller for an sr_ff storage element. Accepts a
//            target value over valid/ready, drives a set or clear pulse of
//            PULSE_CYCLES cycles (never s and r together), then waits for the
//            q/qbar feedback to match. Reports a one-cycle done pulse, or a
//            sticky error (timeout or illegal q==qbar feedback).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   req_valid in   request present
//   req_val   in   target value (1 = set, 0 = clear)
//   req_ready out  high only in IDLE
//   s, r      out  set / reset drive to sr_ff
//   q_fb      in   q from sr_ff
//   qbar_fb   in   qbar from sr_ff
//   done      out  one-cycle completion pulse
//   err       out  sticky error flag (held while in ERR)
//   err_code  out  00 none, 01 timeout, 10 illegal feedback
//   err_clr   in   leaves ERR and clears the error (ignored elsewhere)
// ============================================================================
module sr_ff_driver #(
  parameter int PULSE_CYCLES  = 1,
  parameter int TIMEOUT       = 4,
  parameter int SKIP_IF_EQUAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_val,
  output logic       req_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  input  logic       qbar_fb,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       err_clr
);

  localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of a state is the one where it equals N-1.
  localparam logic [CNT_W-1:0] C_PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WAIT_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] C_ERR_NONE    = 2'b00;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] C_ERR_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_WAIT_FB = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_code_q, err_code_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      target_q   <= 1'b0;
      cnt_q      <= '0;
      err_code_q <= C_ERR_NONE;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          target_d = req_val;
          cnt_d    = '0;
          // Only skip when the feedback is itself legal; an illegal pair
          // must not be mistaken for "already at target".
          if ((SKIP_IF_EQUAL != 0) && (q_fb == req_val) && (q_fb != qbar_fb)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRIVE;
          end
        end
      end

      ST_DRIVE: begin
        if (cnt_q == C_PULSE_LAST) begin
          state_d = ST_WAIT_FB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_FB: begin
        // Illegal feedback outranks a match, which outranks the timeout.
        if (q_fb == qbar_fb) begin
          state_d    = ST_ERR;
          err_code_d = C_ERR_ILLEGAL;
          cnt_d      = '0;
        end else if (q_fb == target_q) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if (cnt_q == C_WAIT_LAST) begin
          state_d    = ST_ERR;
          err_code_d = C_ERR_TIMEOUT;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      ST_ERR: begin
        if (err_clr) begin
          state_d    = ST_IDLE;
          err_code_d = C_ERR_NONE;
          cnt_d      = '0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        err_code_d = C_ERR_NONE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registers only. s and r are mutually exclusive
  // because both require DRIVE and they take opposite polarities of target.
  // --------------------------------------------------------------------------
  assign req_ready = (state_q == ST_IDLE);
  assign s         = (state_q == ST_DRIVE) &  target_q;
  assign r         = (state_q == ST_DRIVE) & ~target_q;
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_ff_driver
// Purpose  : Self-checking bench for sr_ff_driver. A default-parameter DUT is
//            run against a behavioural sr_ff with selectable feedback
//            override; a PULSE_CYCLES=3 DUT checks the pulse width.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_ff_driver;

  localparam int P = 1;  // PULSE_CYCLES of the main DUT

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  // main DUT
  logic       req_valid, req_val, err_clr;
  logic       req_ready, s, r, done, err;
  logic [1:0] err_code;
  logic       q_fb, qbar_fb;
  logic [1:0] fb_mode;  // 0 = sr_ff model, 1 = tied q=0/qbar=1, 2 = q=qbar=1
  logic       q_m;
  // PULSE_CYCLES=3 DUT
  logic       req_valid3, req_val3, err_clr3;
  logic       req_ready3, s3, r3, done3, err3;
  logic [1:0] err_code3;
  logic       q3_m;

  int total = 0;
  int bad   = 0;

  sr_ff_driver #(.PULSE_CYCLES(1), .TIMEOUT(4), .SKIP_IF_EQUAL(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_val(req_val),
    .req_ready(req_ready), .s(s), .r(r), .q_fb(q_fb), .qbar_fb(qbar_fb),
    .done(done), .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  sr_ff_driver #(.PULSE_CYCLES(3), .TIMEOUT(6), .SKIP_IF_EQUAL(0)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_val(req_val3),
    .req_ready(req_ready3), .s(s3), .r(r3), .q_fb(q3_m), .qbar_fb(~q3_m),
    .done(done3), .err(err3), .err_code(err_code3), .err_clr(err_clr3)
  );

  // Behavioural synchronous sr_ff models
  always @(posedge clk) begin
    if (reset)  q_m <= 1'b0;
    else if (s) q_m <= 1'b1;
    else if (r) q_m <= 1'b0;
  end
  always @(posedge clk) begin
    if (reset)   q3_m <= 1'b0;
    else if (s3) q3_m <= 1'b1;
    else if (r3) q3_m <= 1'b0;
  end

  always_comb begin
    case (fb_mode)
      2'd1:    begin q_fb = 1'b0; qbar_fb = 1'b1; end
      2'd2:    begin q_fb = 1'b1; qbar_fb = 1'b1; end
      default: begin q_fb = q_m;  qbar_fb = ~q_m; end
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // s and r must never be high together, on every cycle of the run
  always @(negedge clk) begin
    chk("s_and_r", {31'd0, s & r}, 32'd0);
    chk("s3_and_r3", {31'd0, s3 & r3}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {rv, val, clr, mode[1:0] | s, r, done, err, code[1:0], rdy}
  typedef struct packed {
    logic       rv;
    logic       val;
    logic       clr;
    logic [1:0] mode;
    logic       s;
    logic       r;
    logic       done;
    logic       err;
    logic [1:0] code;
    logic       rdy;
  } vec_t;

  vec_t tbl [23];

  initial begin
    int s_cnt, r_cnt, done_k;
    int c, free_at, drv_from, drv_to, done_at;
    logic drv_val, qm;
    logic rv, vv;

    // ---------------- vectors (expected = state after the edge) ----------
    tbl[0]  = 12'b1_1_0_00_1_0_0_0_00_0;  // accept set -> DRIVE, s
    tbl[1]  = 12'b0_0_0_00_0_0_0_0_00_0;  // WAIT_FB
    tbl[2]  = 12'b0_0_0_00_0_0_1_0_00_0;  // DONE (3 after accept)
    tbl[3]  = 12'b0_0_0_00_0_0_0_0_00_1;  // IDLE
    tbl[4]  = 12'b1_0_0_00_0_1_0_0_00_0;  // accept clear -> r
    tbl[5]  = 12'b0_0_0_00_0_0_0_0_00_0;
    tbl[6]  = 12'b0_0_0_00_0_0_1_0_00_0;
    tbl[7]  = 12'b0_0_0_00_0_0_0_0_00_1;
    tbl[8]  = 12'b1_0_0_00_0_0_1_0_00_0;  // skip: q=0, request 0
    tbl[9]  = 12'b0_0_0_00_0_0_0_0_00_1;
    tbl[10] = 12'b1_1_0_01_1_0_0_0_00_0;  // timeout: feedback stuck at 0
    tbl[11] = 12'b0_0_0_01_0_0_0_0_00_0;  // WAIT 1
    tbl[12] = 12'b0_0_0_01_0_0_0_0_00_0;  // WAIT 2
    tbl[13] = 12'b0_0_0_01_0_0_0_0_00_0;  // WAIT 3
    tbl[14] = 12'b0_0_0_01_0_0_0_0_00_0;  // WAIT 4
    tbl[15] = 12'b0_0_0_01_0_0_0_1_01_0;  // ERR timeout
    tbl[16] = 12'b1_1_0_01_0_0_0_1_01_0;  // sticky, request ignored
    tbl[17] = 12'b0_0_1_00_0_0_0_0_00_1;  // err_clr -> IDLE
    tbl[18] = 12'b1_0_0_00_0_1_0_0_00_0;  // q=1, clear -> r
    tbl[19] = 12'b0_0_0_10_0_0_0_0_00_0;  // WAIT with q==qbar forced
    tbl[20] = 12'b0_0_0_10_0_0_0_1_10_0;  // ERR illegal
    tbl[21] = 12'b0_0_1_00_0_0_0_0_00_1;  // clear
    tbl[22] = 12'b0_0_1_00_0_0_0_0_00_1;  // err_clr ignored in IDLE

    reset = 1'b1;
    req_valid = 1'b0; req_val = 1'b0; err_clr = 1'b0; fb_mode = 2'd0;
    req_valid3 = 1'b0; req_val3 = 1'b0; err_clr3 = 1'b0;

    // ---------------- reset ----------------
    repeat (5) step();
    reset = 1'b0;
    chk("rst_s", {31'd0, s}, 32'd0);
    chk("rst_r", {31'd0, r}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_ready3", {31'd0, req_ready3}, 32'd1);

    // ---------------- PULSE_CYCLES=3 width and latency ----------------
    req_valid3 = 1'b1; req_val3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    s_cnt = 0; r_cnt = 0; done_k = 0;
    for (int k = 1; k <= 8; k++) begin
      if (s3) s_cnt++;
      if (r3) r_cnt++;
      if (done3 && done_k == 0) done_k = k;
      if (k < 8) step();
    end
    chk("p3_s_cycles", s_cnt, 3);
    chk("p3_r_cycles", r_cnt, 0);
    chk("p3_done_lat", done_k, 5);
    chk("p3_ready", {31'd0, req_ready3}, 32'd1);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 23; i++) begin
      req_valid = tbl[i].rv;
      req_val   = tbl[i].val;
      err_clr   = tbl[i].clr;
      fb_mode   = tbl[i].mode;
      step();
      chk($sformatf("v%0d_s", i), {31'd0, s}, {31'd0, tbl[i].s});
      chk($sformatf("v%0d_r", i), {31'd0, r}, {31'd0, tbl[i].r});
      chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, tbl[i].done});
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, tbl[i].err});
      chk($sformatf("v%0d_code", i), {30'd0, err_code}, {30'd0, tbl[i].code});
      chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, {31'd0, tbl[i].rdy});
    end
    req_valid = 1'b0; err_clr = 1'b0; fb_mode = 2'd0;

    // ---------------- reset in first DRIVE cycle ----------------
    req_valid = 1'b1; req_val = 1'b1;
    step();
    req_valid = 1'b0;
    chk("mid_drive_s", {31'd0, s}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_s", {31'd0, s}, 32'd0);
    chk("mid_rst_r", {31'd0, r}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_no_done", {31'd0, done}, 32'd0);
      step();
    end
    req_valid = 1'b1; req_val = 1'b1;
    step();
    req_valid = 1'b0;
    chk("after_rst_s", {31'd0, s}, 32'd1);
    step();
    step();
    chk("after_rst_done", {31'd0, done}, 32'd1);
    step();
    chk("after_rst_ready", {31'd0, req_ready}, 32'd1);

    // ---------------- randomized, against a transaction-level model -------
    // One command in flight at a time: an accepted command either completes
    // next cycle (target already held) or drives P cycles and reports done
    // P+2 cycles after the accept edge, followed by one idle cycle.
    c = 0; free_at = 0; drv_from = -10; drv_to = -10; done_at = -10;
    drv_val = 1'b0; qm = q_m;
    for (int n = 0; n < 400; n++) begin
      chk("rnd_ready", {31'd0, req_ready}, {31'd0, (c >= free_at)});
      chk("rnd_s", {31'd0, s}, {31'd0, (c >= drv_from && c <= drv_to && drv_val)});
      chk("rnd_r", {31'd0, r}, {31'd0, (c >= drv_from && c <= drv_to && !drv_val)});
      chk("rnd_done", {31'd0, done}, {31'd0, (c == done_at)});
      chk("rnd_err", {31'd0, err}, 32'd0);
      rv = ($urandom_range(0, 1) == 1);
      vv = ($urandom_range(0, 1) == 1);
      req_valid = rv;
      req_val   = vv;
      err_clr   = ($urandom_range(0, 4) == 0);
      if (rv && c >= free_at) begin
        if (qm == vv) begin
          done_at = c + 1;
          free_at = c + 2;
        end else begin
          drv_from = c + 1;
          drv_to   = c + P;
          drv_val  = vv;
          done_at  = c + P + 2;
          free_at  = c + P + 3;
          qm       = vv;
        end
      end
      step();
      c++;
    end
    req_valid = 1'b0; err_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sr_ff_driver.md
Name: sr_ff_driver

Overview:
Command-side controller for the `sr_ff` storage element: it produces the `s`/`r` inputs that `sr_ff` consumes and checks the `q`/`qbar` that `sr_ff` returns. It accepts a target-value request over a valid/ready handshake and drives a clean set or clear pulse of programmable width. It never drives `s` and `r` high together, then waits for the flip-flop's feedback to match the target. It reports `done`, or a sticky error on timeout or illegal feedback, so upstream logic never handles raw S/R encoding.

Parameters:
PULSE_CYCLES, 1, number of cycles `s` or `r` is held high per command (must be ≥1)
TIMEOUT, 4, maximum WAIT_FB cycles allowed for feedback to match the target (must be ≥1)
SKIP_IF_EQUAL, 1, 1 = a request whose target already equals `q_fb` completes with no pulse

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_val  input  1  target flip-flop value (1 = set, 0 = clear)
req_ready  output  1  driver can accept a request
s  output  1  set drive to `sr_ff`
r  output  1  reset drive to `sr_ff`
q_fb  input  1  `q` from `sr_ff`
qbar_fb  input  1  `qbar` from `sr_ff`
done  output  1  one-cycle completion pulse
err  output  1  sticky error flag
err_code  output  2  00 none, 01 timeout, 10 illegal feedback (`q_fb==qbar_fb`)
err_clr  input  1  clears the error and returns to IDLE

Behaviour:
- Reset (sync, active-high) forces state IDLE and sets `s=0`, `r=0`, `done=0`, `err=0`, `err_code=00`, target=0 and all counters 0. `req_ready` is 1 in the first cycle after reset.
- Reset mid-operation: `s`/`r` are 0 after the reset edge, no `done` is issued, and the in-flight command is dropped.
- All outputs are registered or decoded purely from the state register; no combinational path from inputs to outputs.
- `req_ready=1` only in IDLE. A transfer occurs on a rising edge where `req_valid & req_ready` are both 1; the target latches from `req_val` on that edge.
- States: IDLE, DRIVE, WAIT_FB, DONE, ERR.
- IDLE:
  - On transfer, if SKIP_IF_EQUAL=1, `q_fb==req_val` and `q_fb!=qbar_fb`, go to DONE.
  - Otherwise, on transfer, go to DRIVE.
- DRIVE: `s=target`, `r=~target` for exactly PULSE_CYCLES cycles (pulse counter), then go to WAIT_FB. `s&r` is never 1 in any state.
- WAIT_FB: `s=r=0`. Feedback is evaluated every cycle, with priority in this order:
  - `q_fb==qbar_fb`: go to ERR, `err_code=10`.
  - `q_fb==target`: go to DONE.
  - Wait counter reaches TIMEOUT with no match: go to ERR, `err_code=01`.
- DONE: `done=1` for exactly one cycle, then go to IDLE.
- ERR: `err=1` and `req_ready=0` until an edge with `err_clr=1`; that edge returns to IDLE and clears `err` and `err_code`. `err_clr` is ignored outside ERR.
- Latency with PULSE_CYCLES=1 and a synchronous `sr_ff` (q updates on the edge that samples `s`/`r`):
  - Edge 0: accept.
  - Cycle after edge 0: DRIVE, `s` or `r` high.
  - Edge 2: WAIT_FB sees the match.
  - Cycle after edge 2: `done` high, i.e. 3 cycles from the accept edge.
  - General formula: PULSE_CYCLES+2.
- Skip path: `done` is high in the cycle after the accept edge; `s` and `r` stay 0.
- `req_valid` held high across completion: the next command is accepted on the first IDLE cycle after DONE, so there is one idle cycle between commands.
- Counters are sized `$clog2(max(PULSE_CYCLES,TIMEOUT))+1`; they reset to 0 on every state entry and never wrap.

Test Plan:
1. Reset behaviour: hold `reset=1` for 5 cycles, then release → `s=0`, `r=0`, `done=0`, `err=0`, `req_ready=1`; `s&r==0` asserted on every cycle of the whole run.
2. Set then clear against a `sr_ff` instance: `req_val=1` → `s` high for 1 cycle, `q=1`, `done` 3 cycles after accept; then `req_val=0` → `r` high for 1 cycle, `q=0`, `done` 3 cycles after accept.
3. Skip and pulse width:
   - SKIP_IF_EQUAL=1 with `q=0`, request 0 → `done` 1 cycle after accept, no `s`/`r` activity.
   - PULSE_CYCLES=3 → `s` high for exactly 3 cycles.
4. Timeout: tie `q_fb=0`, `qbar_fb=1`, request 1 → after 4 WAIT_FB cycles `err=1`, `err_code=01`, `req_ready=0`; pulse `err_clr` → IDLE and `req_ready=1`.
5. Illegal feedback: force `q_fb=qbar_fb=1` during WAIT_FB → ERR with `err_code=10` on the next edge, `done` never asserts.
6. Reset mid-DRIVE: assert `reset` in the first DRIVE cycle → `s=r=0` after that edge, no `done`, and a new request is accepted normally afterwards.
